// File: rtl/count_disp_pkg.sv
// rtl/count_disp_pkg.sv - shared types and segment constants for the count display driver
package count_disp_pkg;

    typedef enum logic [1:0] {
        S_UNITS = 2'd0,
        S_GAP0  = 2'd1,
        S_TENS  = 2'd2,
        S_GAP1  = 2'd3
    } disp_state_t;

    // Active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };
    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;
    localparam logic [1:0] AN_OFF   = 2'b11;

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit digit to active-low 7-segment pattern, non-decimal inputs dark
module seg7_decode
    import count_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        if (digit <= 4'd9) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/count_seg_display.sv
// rtl/count_seg_display.sv - glitch-filtered two-digit multiplexed 7-segment driver
module count_seg_display
    import count_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 8,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] count,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic [3:0] disp_value
);

    localparam int MAX_DWELL = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
    localparam int RW        = (MAX_DWELL > 2) ? $clog2(MAX_DWELL) : 1;
    localparam logic [RW-1:0] DIGIT_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [RW-1:0] GAP_LAST   = RW'(BLANK_CYC - 1);

    disp_state_t   state;
    logic [RW-1:0] rdiv;
    logic [3:0]    cq1;
    logic [3:0]    cq2;
    logic          tens;
    logic [3:0]    units;
    logic [3:0]    dec_in;
    logic [6:0]    dec_seg;
    logic          rdiv_done;

    always_comb begin
        tens  = (disp_value >= 4'd10);
        units = tens ? (disp_value - 4'd10) : disp_value;
    end

    // The only state that loads a tens pattern next is S_GAP0; all others load units.
    always_comb begin
        dec_in = (state == S_GAP0) ? {3'b000, tens} : units;
    end

    seg7_decode u_decode (
        .digit (dec_in),
        .seg   (dec_seg)
    );

    always_comb begin
        if (state == S_UNITS || state == S_TENS) begin
            rdiv_done = (rdiv == DIGIT_LAST);
        end else begin
            rdiv_done = (rdiv == GAP_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cq1        <= 4'd0;
            cq2        <= 4'd0;
            disp_value <= 4'd0;
            state      <= S_GAP1;
            rdiv       <= '0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
        end else begin
            cq1 <= count;
            cq2 <= cq1;
            if (cq1 == cq2) begin
                disp_value <= cq2;
            end

            // Outputs load only on state entry, so a digit is frozen for its whole dwell.
            if (rdiv_done) begin
                rdiv <= '0;
                case (state)
                    S_UNITS: begin
                        state <= S_GAP0;
                        an    <= AN_OFF;
                        seg   <= SEG_OFF;
                    end
                    S_GAP0: begin
                        state <= S_TENS;
                        if (LZ_BLANK && !tens) begin
                            an  <= AN_OFF;
                            seg <= SEG_OFF;
                        end else begin
                            an  <= AN_TENS;
                            seg <= dec_seg;
                        end
                    end
                    S_TENS: begin
                        state <= S_GAP1;
                        an    <= AN_OFF;
                        seg   <= SEG_OFF;
                    end
                    default: begin
                        state <= S_UNITS;
                        an    <= AN_UNITS;
                        seg   <= dec_seg;
                    end
                endcase
            end else begin
                rdiv <= rdiv + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_count_seg_display.sv
// tb/tb_count_seg_display.sv - scoreboard bench for count_seg_display
module tb_count_seg_display;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count;
    logic [6:0] seg;
    logic [1:0] an;
    logic [3:0] disp_value;

    count_seg_display #(
        .REFRESH_DIV (4),
        .BLANK_CYC   (1),
        .LZ_BLANK    (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .seg        (seg),
        .an         (an),
        .disp_value (disp_value)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_units = -1;
    logic [1:0]  prev_an  = 2'b11;
    logic [8:0]  exp_q[$];
    string       probe_name[$];
    int          probe_kind[$];
    logic [31:0] probe_exp[$];
    logic [8:0]  mon_e;
    string       pn;
    int          pk;
    logic [31:0] pe;
    logic [31:0] pa;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, expv);
        end
    endtask

    // Monitor: pops a frame expectation each time a digit lights, and services probes.
    always @(negedge clk) begin
        chk("an_not_both_lit", {31'd0, (an === 2'b00)}, 32'd0);
        if (reset) begin
            last_units = -1;
        end else if (an !== 2'b11 && prev_an === 2'b11) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame actual=%0h required=none", {an, seg});
            end else begin
                mon_e = exp_q.pop_front();
                chk("frame", {23'd0, an, seg}, {23'd0, mon_e});
            end
            if (an === 2'b10) begin
                if (last_units >= 0) chk("scan_period", cyc - last_units, 32'd10);
                last_units = cyc;
            end
        end
        while (probe_name.size() != 0) begin
            pn = probe_name.pop_front();
            pk = probe_kind.pop_front();
            pe = probe_exp.pop_front();
            case (pk)
                0:       pa = {30'd0, an};
                1:       pa = {25'd0, seg};
                2:       pa = {28'd0, disp_value};
                default: pa = exp_q.size();
            endcase
            chk(pn, pa, pe);
            if (pk == 3) exp_q.delete();
        end
        prev_an = an;
    end

    task automatic edges(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic probe(input string name, input int kind, input logic [31:0] expv);
        probe_name.push_back(name);
        probe_kind.push_back(kind);
        probe_exp.push_back(expv);
    endtask

    task automatic push(input logic [1:0] a, input logic [6:0] s);
        exp_q.push_back({a, s});
    endtask

    task automatic start(input logic [3:0] c, input int n);
        reset = 1'b1;
        count = c;
        edges(n);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            edges(1);
            n++;
        end
        probe(name, 3, 32'd0);
        edges(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        count = 4'd0;

        // 1: reset state, first units frame 0, tens blanked
        start(4'd0, 3);
        probe("rst_an", 0, 2'b11);
        probe("rst_seg", 1, 7'h7F);
        probe("rst_disp", 2, 4'd0);
        push(2'b10, 7'h40);
        push(2'b10, 7'h40);
        reset = 1'b0;
        edges(1);
        probe("s1_first_an", 0, 2'b10);
        edges(6);
        probe("s1_tens_blank_an", 0, 2'b11);
        probe("s1_tens_blank_seg", 1, 7'h7F);
        drain("s1_drain");

        // 2: count 15 held
        start(4'd15, 2);
        push(2'b10, 7'h40);
        push(2'b01, 7'h79);
        push(2'b10, 7'h12);
        push(2'b01, 7'h79);
        reset = 1'b0;
        edges(2);
        probe("s2_disp_e2", 2, 4'd0);
        edges(1);
        probe("s2_disp_e3", 2, 4'd15);
        drain("s2_drain");

        // 3: single-cycle glitch 7 -> 9 -> 7
        start(4'd7, 2);
        push(2'b10, 7'h40);
        push(2'b10, 7'h78);
        push(2'b10, 7'h78);
        reset = 1'b0;
        edges(4);
        probe("s3_disp_pre", 2, 4'd7);
        count = 4'd9;
        edges(1);
        count = 4'd7;
        for (int i = 0; i < 8; i++) begin
            edges(1);
            probe("s3_disp_hold", 2, 4'd7);
        end
        drain("s3_drain");

        // 4: wrap 15 -> 0
        start(4'd15, 2);
        push(2'b10, 7'h40);
        push(2'b01, 7'h79);
        push(2'b10, 7'h12);
        push(2'b10, 7'h40);
        reset = 1'b0;
        edges(12);
        count = 4'd0;
        edges(1);
        probe("s4_disp_e13", 2, 4'd15);
        edges(1);
        probe("s4_disp_e14", 2, 4'd15);
        edges(1);
        probe("s4_disp_e15", 2, 4'd0);
        drain("s4_drain");

        // 5: change 3 -> 8 mid units dwell, pattern frozen
        start(4'd3, 2);
        push(2'b10, 7'h40);
        push(2'b10, 7'h30);
        push(2'b10, 7'h00);
        reset = 1'b0;
        edges(12);
        count = 4'd8;
        for (int i = 0; i < 2; i++) begin
            edges(1);
            probe("s5_seg_frozen", 1, 7'h30);
            probe("s5_an_units", 0, 2'b10);
        end
        edges(1);
        probe("s5_disp_new", 2, 4'd8);
        drain("s5_drain");

        // 6: reset during tens dwell
        start(4'd12, 2);
        push(2'b10, 7'h40);
        push(2'b01, 7'h79);
        reset = 1'b0;
        edges(7);
        probe("s6_tens_an", 0, 2'b01);
        probe("s6_tens_seg", 1, 7'h79);
        reset = 1'b1;
        edges(1);
        probe("s6_abort_an", 0, 2'b11);
        probe("s6_abort_seg", 1, 7'h7F);
        probe("s6_abort_disp", 2, 4'd0);
        push(2'b10, 7'h40);
        push(2'b01, 7'h79);
        push(2'b10, 7'h24);
        reset = 1'b0;
        edges(1);
        probe("s6_first_units_an", 0, 2'b10);
        probe("s6_first_units_seg", 1, 7'h40);
        drain("s6_drain");

        edges(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
